// File: rtl/state_history_display.sv
// History display for the Moore FSM: keeps the last DIGITS captured states (newest first),
// scans them onto a common-anode 7-segment display and counts captured FSM steps.
module state_history_display #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [2:0]        state_in,
  input  logic              freeze,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              dp,
  output logic [7:0]        step_cnt
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [6:0]       SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [2:0] s);
    logic [6:0] r;
    case (s)
      3'd0:    r = 7'b1000000;
      3'd1:    r = 7'b1111001;
      3'd2:    r = 7'b0100100;
      3'd3:    r = 7'b0110000;
      3'd4:    r = 7'b0011001;
      3'd5:    r = 7'b0010010;
      default: r = 7'b0111111;
    endcase
    return r;
  endfunction

  logic              tick_s1, tick_s2, tick_s3;
  logic              edge_p0, capture_p0;
  logic [2:0]        hist [DIGITS];
  logic [DIGITS-1:0] valid;
  logic [CNT_W-1:0]  scan_cnt;
  logic [IDX_W-1:0]  scan_idx;
  logic [2:0]        cur_state;
  logic              cur_vld;

  // Stage s1..s3: synchronise clk_div and detect its rising edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_s1 <= 1'b0;
      tick_s2 <= 1'b0;
      tick_s3 <= 1'b0;
    end else begin
      tick_s1 <= tick;
      tick_s2 <= tick_s1;
      tick_s3 <= tick_s2;
    end
  end

  assign edge_p0    = tick_s2 & ~tick_s3;
  // An edge seen while frozen is discarded, not deferred.
  assign capture_p0 = edge_p0 & ~freeze;

  // Stage p0: history shift and step count
  always_ff @(posedge clk) begin
    if (capture_p0) begin
      for (int k = DIGITS - 1; k > 0; k--) begin
        hist[k] <= hist[k-1];
      end
      hist[0] <= state_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid    <= '0;
      step_cnt <= 8'd0;
    end else if (capture_p0) begin
      valid    <= {valid[DIGITS-2:0], 1'b1};
      step_cnt <= step_cnt + 8'd1;
    end
  end

  // Digit scan runs free of tick and freeze.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == CNT_LAST) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    cur_state = hist[scan_idx];
    cur_vld   = valid[scan_idx];
  end

  // Stage p1: registered display outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg <= SEG_BLANK;
      an  <= ~DIGITS'(1);
      dp  <= 1'b1;
    end else begin
      seg <= cur_vld ? seg_decode(cur_state) : SEG_BLANK;
      an  <= ~(DIGITS'(1) << scan_idx);
      dp  <= ~((scan_idx == IDX_W'(0)) & valid[0]);
    end
  end

endmodule

// File: tb/tb_state_history_display.sv
// Scoreboard bench for state_history_display with DIGITS=4, SCAN_DIV=4.
module tb_state_history_display;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              tick = 1'b0;
  logic [2:0]        state_in = 3'd0;
  logic              freeze = 1'b0;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;
  logic              dp;
  logic [7:0]        step_cnt;

  always #5 clk = ~clk;

  state_history_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .reset(reset), .tick(tick), .state_in(state_in), .freeze(freeze),
    .seg(seg), .an(an), .dp(dp), .step_cnt(step_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // kind 0: display word once an matches; 1: step_cnt; 2: display word now; 3: an after next negedge
  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  logic [2:0]        m_hist [DIGITS];
  logic [DIGITS-1:0] m_vld;
  logic [7:0]        m_cnt;

  function automatic logic [6:0] dec(input logic [2:0] s);
    case (s)
      3'd0:    return 7'b1000000;
      3'd1:    return 7'b1111001;
      3'd2:    return 7'b0100100;
      3'd3:    return 7'b0110000;
      3'd4:    return 7'b0011001;
      3'd5:    return 7'b0010010;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic push(input string tag, input int kind, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.kind = kind; e.val = v;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    m_vld = '0;
    m_cnt = 8'd0;
  endtask

  task automatic do_tick(input logic [2:0] s);
    @(negedge clk);
    state_in = s;
    tick = 1'b1;
    if (!freeze) begin
      for (int k = DIGITS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = s;
      m_vld = {m_vld[DIGITS-2:0], 1'b1};
      m_cnt = m_cnt + 8'd1;
    end
    repeat (8) @(negedge clk);
    tick = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  function automatic logic [31:0] disp_word(input int d);
    logic [DIGITS-1:0] a;
    logic [6:0]        s;
    logic              p;
    a = ~(DIGITS'(1) << d);
    s = m_vld[d] ? dec(m_hist[d]) : 7'b1111111;
    p = (d == 0 && m_vld[0]) ? 1'b0 : 1'b1;
    return {20'd0, a, s, p};
  endfunction

  task automatic expect_display(input string name);
    for (int d = 0; d < DIGITS; d++)
      push($sformatf("%s_digit%0d", name, d), 0, disp_word(d));
    push($sformatf("%s_step", name), 1, {24'd0, m_cnt});
  endtask

  task automatic drain();
    exp_t e;
    int   n;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        1: check(e.tag, {24'd0, step_cnt}, e.val);
        2: check(e.tag, {20'd0, an, seg, dp}, e.val);
        3: begin
          @(negedge clk);
          check(e.tag, {28'd0, an}, e.val);
        end
        default: begin
          n = 0;
          while (an !== e.val[11:8] && n < 40) begin
            @(negedge clk);
            n++;
          end
          check(e.tag, {20'd0, an, seg, dp}, e.val);
        end
      endcase
    end
  endtask

  initial begin
    logic [3:0] an_seq [5];
    an_seq[0] = 4'b1110; an_seq[1] = 4'b1101; an_seq[2] = 4'b1011;
    an_seq[3] = 4'b0111; an_seq[4] = 4'b1110;

    // Reset values, then the idle scan sequence
    model_reset();
    repeat (3) @(negedge clk);
    push("rst_disp", 2, disp_word(0));
    push("rst_step", 1, 32'd0);
    drain();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) push($sformatf("an_seq%0d", i), 3, {28'd0, an_seq[i/4]});
    drain();

    // Three captures: 3,1,5
    do_tick(3'd3); do_tick(3'd1); do_tick(3'd5);
    expect_display("t2");
    drain();

    // Five more: oldest entries fall off
    do_tick(3'd0); do_tick(3'd1); do_tick(3'd2); do_tick(3'd3); do_tick(3'd4);
    expect_display("t3");
    drain();

    // Frozen edges are lost
    freeze = 1'b1;
    do_tick(3'd5); do_tick(3'd0);
    freeze = 1'b0;
    expect_display("t4");
    drain();

    // Illegal states show a dash
    do_tick(3'd6); do_tick(3'd7);
    expect_display("t5");
    drain();

    // Fresh reset, 256 captures wrap the step counter
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 256; i++) do_tick(3'((i * 5 + 1) % 6));
    expect_display("t6");
    drain();

    // Asynchronous reset between clock edges
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    model_reset();
    push("async_disp", 2, disp_word(0));
    push("async_step", 1, 32'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
